// File: rtl/cpu_pkg.sv
// Shared widths, register control codes and ALU op bundle for the CPU datapath.
package cpu_pkg;

  localparam int unsigned DW     = 16;
  localparam int unsigned AW     = 11;
  localparam int unsigned OPW    = 4;
  localparam int unsigned OP_LSB = AW;
  localparam int unsigned OP_MSB = OP_LSB + OPW - 1;

  localparam logic [2:0] CTL_HOLD = 3'b000;
  localparam logic [2:0] CTL_INC  = 3'b001;
  localparam logic [2:0] CTL_CLR  = 3'b010;
  localparam logic [2:0] CTL_LOAD = 3'b100;

  localparam logic [1:0] DRSRC_PC  = 2'b00;
  localparam logic [1:0] DRSRC_MEM = 2'b01;
  localparam logic [1:0] DRSRC_AC  = 2'b10;

  // Field order is also the selection priority, highest first.
  typedef struct packed {
    logic add;
    logic sub;
    logic drtac;
    logic op_and;
    logic op_or;
    logic op_xor;
    logic com;
    logic shl;
    logic shr;
  } alu_ops_t;

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: priority-selected result for AC plus the carry/link update.
module datapath_alu
  import cpu_pkg::*;
(
  input  logic [DW-1:0] i_ac,
  input  logic [DW-1:0] i_dr,
  input  logic          i_e,
  input  alu_ops_t      i_ops,
  output logic [DW-1:0] o_result,
  output logic          o_e_next,
  output logic          o_e_upd,
  output logic          o_op_err
);

  logic [DW:0] w_sum;
  logic [DW:0] w_diff;

  assign w_sum    = {1'b0, i_ac} + {1'b0, i_dr};
  // Carry out of AC + ~DR + 1 is the "no borrow" flag.
  assign w_diff   = {1'b0, i_ac} + {1'b0, ~i_dr} + (DW+1)'(1);
  assign o_op_err = ($countones(i_ops) != 1);

  always_comb begin
    o_result = i_ac;
    o_e_next = i_e;
    o_e_upd  = 1'b0;
    if (i_ops.add) begin
      o_result = w_sum[DW-1:0];
      o_e_next = w_sum[DW];
      o_e_upd  = 1'b1;
    end else if (i_ops.sub) begin
      o_result = w_diff[DW-1:0];
      o_e_next = w_diff[DW];
      o_e_upd  = 1'b1;
    end else if (i_ops.drtac) begin
      o_result = i_dr;
    end else if (i_ops.op_and) begin
      o_result = i_ac & i_dr;
    end else if (i_ops.op_or) begin
      o_result = i_ac | i_dr;
    end else if (i_ops.op_xor) begin
      o_result = i_ac ^ i_dr;
    end else if (i_ops.com) begin
      o_result = ~i_ac;
    end else if (i_ops.shl) begin
      o_result = {i_ac[DW-2:0], i_e};
      o_e_next = i_ac[DW-1];
      o_e_upd  = 1'b1;
    end else if (i_ops.shr) begin
      o_result = {i_e, i_ac[DW-1:1]};
      o_e_next = i_ac[0];
      o_e_upd  = 1'b1;
    end
  end

endmodule

// File: rtl/cpu_datapath.sv
// Register datapath of the microprogrammed CPU: AC, DR, AR, PC, E, ALU and
// the control-legality flag fed back to the sequencer.
module cpu_datapath
  import cpu_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic [2:0]     AC_control,
  input  logic [2:0]     DR_control,
  input  logic [2:0]     AR_control,
  input  logic [2:0]     PC_control,
  input  logic           ADD,
  input  logic           DRTAC,
  input  logic           SUB,
  input  logic           OR,
  input  logic           AND,
  input  logic           XOR,
  input  logic           COM,
  input  logic           SHL,
  input  logic           SHR,
  input  logic [1:0]     DR_mux,
  input  logic           AR_mux,
  input  logic           MEM_wen,
  input  logic           HALT,
  input  logic [DW-1:0]  mem_rdata,
  output logic [AW-1:0]  mem_addr,
  output logic [DW-1:0]  mem_wdata,
  output logic           mem_we,
  output logic           I,
  output logic [OPW-1:0] OPCode,
  output logic           S,
  output logic           Z,
  output logic           E,
  output logic           ctrl_err
);

  logic [DW-1:0] r_ac, r_dr, w_ac_nxt, w_dr_nxt, w_alu_res;
  logic [AW-1:0] r_ar, r_pc, w_ar_nxt, w_pc_nxt;
  logic          r_e, r_ctrl_err, w_e_nxt, w_err_nxt;
  logic          w_alu_e, w_alu_e_upd, w_alu_err;
  alu_ops_t      w_ops;

  assign w_ops = alu_ops_t'({ADD, SUB, DRTAC, AND, OR, XOR, COM, SHL, SHR});

  datapath_alu u_alu (
    .i_ac     (r_ac),
    .i_dr     (r_dr),
    .i_e      (r_e),
    .i_ops    (w_ops),
    .o_result (w_alu_res),
    .o_e_next (w_alu_e),
    .o_e_upd  (w_alu_e_upd),
    .o_op_err (w_alu_err)
  );

  // Next-state for every register; all sources are pre-edge values.
  always_comb begin
    w_ac_nxt  = r_ac;
    w_dr_nxt  = r_dr;
    w_ar_nxt  = r_ar;
    w_pc_nxt  = r_pc;
    w_e_nxt   = r_e;
    w_err_nxt = 1'b0;
    if (!HALT) begin
      case (AC_control)
        CTL_LOAD: begin
          if (w_alu_err) w_err_nxt = 1'b1;
          if (w_ops != '0) begin
            w_ac_nxt = w_alu_res;
            if (w_alu_e_upd) w_e_nxt = w_alu_e;
          end
        end
        CTL_CLR:  w_ac_nxt = '0;
        CTL_INC:  w_ac_nxt = r_ac + DW'(1);
        CTL_HOLD: ;
        default:  w_err_nxt = 1'b1;
      endcase

      case (DR_control)
        CTL_LOAD: begin
          case (DR_mux)
            DRSRC_PC:  w_dr_nxt = DW'(r_pc);
            DRSRC_MEM: w_dr_nxt = mem_rdata;
            DRSRC_AC:  w_dr_nxt = r_ac;
            default:   w_err_nxt = 1'b1;
          endcase
        end
        CTL_CLR:  w_dr_nxt = '0;
        CTL_INC:  w_dr_nxt = r_dr + DW'(1);
        CTL_HOLD: ;
        default:  w_err_nxt = 1'b1;
      endcase

      case (AR_control)
        CTL_LOAD: w_ar_nxt = AR_mux ? r_dr[AW-1:0] : r_pc;
        CTL_CLR:  w_ar_nxt = '0;
        CTL_INC:  w_ar_nxt = r_ar + AW'(1);
        CTL_HOLD: ;
        default:  w_err_nxt = 1'b1;
      endcase

      case (PC_control)
        CTL_LOAD: w_pc_nxt = r_ar;
        CTL_CLR:  w_pc_nxt = '0;
        CTL_INC:  w_pc_nxt = r_pc + AW'(1);
        CTL_HOLD: ;
        default:  w_err_nxt = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ac       <= '0;
      r_dr       <= '0;
      r_ar       <= '0;
      r_pc       <= '0;
      r_e        <= 1'b0;
      r_ctrl_err <= 1'b0;
    end else begin
      r_ac       <= w_ac_nxt;
      r_dr       <= w_dr_nxt;
      r_ar       <= w_ar_nxt;
      r_pc       <= w_pc_nxt;
      r_e        <= w_e_nxt;
      r_ctrl_err <= w_err_nxt;
    end
  end

  assign mem_addr  = r_ar;
  assign mem_wdata = r_dr;
  assign mem_we    = MEM_wen & ~HALT;
  assign I         = r_dr[DW-1];
  assign OPCode    = r_dr[OP_MSB:OP_LSB];
  assign S         = r_ac[DW-1];
  assign Z         = (r_ac == '0);
  assign E         = r_e;
  assign ctrl_err  = r_ctrl_err;

endmodule
